prefix_adder_pipe: RTL and testbench

- Parametrised, pipelined Sklansky parallel-prefix adder/subtractor; successor to the fixed-width combinational adder_stage* chain.
- Width and register placement between prefix levels are parameters; carry-in, subtract mode, flags and valid/ready flow control are added.
- Sits in the execute unit as the shared ADD/SUB/CMP datapath; every prefix level reuses gp_cell.

---
 rtl/prefix_adder_pipe_pkg.sv | 20 ++
 rtl/prefix_adder_pipe_if.sv | 30 +++
 rtl/prefix_adder_pipe_gp_cell.sv | 12 +
 rtl/prefix_adder_pipe_prefix_level.sv | 81 ++++++++
 rtl/prefix_adder_pipe.sv | 117 +++++++++++
 tb/tb_prefix_adder_pipe.sv | 271 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/prefix_adder_pipe_pkg.sv
// Shared constants, flag bundle and index helper for the pipelined Sklansky adder.
// Imported by the interface, the prefix level and the top.
package prefix_adder_pipe_pkg;

  localparam int unsigned LEN_DATA              = 64;
  localparam int unsigned LOG2_LEN_DATA         = 6;
  localparam logic [7:0]  ADD_PIPE_MASK_DEFAULT = 8'b0000_1000;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic cout;
  } flags_t;

  // Sklansky partner of bit i at level k: top bit of the lower half of its 2^(k+1) block.
  function automatic int right_index(input int i, input int k);
    return ((i >> (k + 1)) << (k + 1)) + (1 << k) - 1;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_if.sv
// Operand/result bundle of the adder. Both sides use valid/ready: a beat moves
// on a rising edge where valid and ready are both 1; valid and its payload stay put until then.
interface prefix_adder_pipe_if
  import prefix_adder_pipe_pkg::*;
#(
  parameter int WIDTH = LEN_DATA
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/prefix_adder_pipe_gp_cell.sv
// Generate/propagate combine: left is the more significant group.
module gp_cell (
  input  logic gl,
  input  logic pl,
  input  logic gr,
  input  logic pr,
  output logic g,
  output logic p
);
  assign g = gl | (pl & gr);
  assign p = pl & pr;
endmodule

// File: rtl/prefix_adder_pipe_prefix_level.sv
// One Sklansky prefix level built from gp_cell, with an optional register stage
// that carries the sum-propagate, carry-in and valid bit alongside.
module prefix_level
  import prefix_adder_pipe_pkg::*;
#(
  parameter int WIDTH = LEN_DATA,
  parameter int LEVEL = 0,
  parameter bit REG   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] xp_i,
  input  logic             c_i,
  input  logic             v_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] xp_o,
  output logic             c_o,
  output logic             v_o
);
  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] p_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> LEVEL) & 1) == 1) begin : g_cell
      localparam int R = right_index(i, LEVEL);
      gp_cell u_cell (
        .gl (g_i[i]),
        .pl (p_i[i]),
        .gr (g_i[R]),
        .pr (p_i[R]),
        .g  (g_d[i]),
        .p  (p_d[i])
      );
    end else begin : g_pass
      assign g_d[i] = g_i[i];
      assign p_d[i] = p_i[i];
    end
  end

  if (REG) begin : g_reg
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] xp_q;
    logic             c_q;
    logic             v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        g_q  <= '0;
        p_q  <= '0;
        xp_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (en) begin
        g_q  <= g_d;
        p_q  <= p_d;
        xp_q <= xp_i;
        c_q  <= c_i;
        v_q  <= v_i;
      end
    end

    assign g_o  = g_q;
    assign p_o  = p_q;
    assign xp_o = xp_q;
    assign c_o  = c_q;
    assign v_o  = v_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ rst ^ en;
    assign g_o  = g_d;
    assign p_o  = p_d;
    assign xp_o = xp_i;
    assign c_o  = c_i;
    assign v_o  = v_i;
  end
endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky add/sub/compare datapath: operand register, LOG2W prefix
// levels with optional registers, and a registered sum/flag stage under one global enable.
module prefix_adder_pipe
  import prefix_adder_pipe_pkg::*;
#(
  parameter int         WIDTH     = LEN_DATA,
  parameter logic [7:0] PIPE_MASK = ADD_PIPE_MASK_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  prefix_adder_pipe_if.slave  bus
);
  localparam int LOG2W = $clog2(WIDTH);

  logic en;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g0_d, g0_q;
  logic [WIDTH-1:0] p0_d, p0_q;
  logic             c0_d, c0_q;
  logic             v0_d, v0_q;

  logic [LOG2W:0][WIDTH-1:0] g_s;
  logic [LOG2W:0][WIDTH-1:0] p_s;
  logic [LOG2W:0][WIDTH-1:0] xp_s;
  logic [LOG2W:0]            c_s;
  logic [LOG2W:0]            v_s;

  logic [WIDTH-1:0] sum_d, sum_q;
  flags_t           flags_d, flags_q;
  logic             out_valid_d, out_valid_q;
  logic             unused_p;

  // Whole pipe moves as one; nothing advances while a result waits to be taken.
  assign en = bus.out_ready | ~out_valid_q;

  always_comb begin
    b_eff   = bus.sub ? ~bus.b : bus.b;
    c0_d    = bus.sub | bus.cin;
    p0_d    = bus.a ^ b_eff;
    g0_d    = bus.a & b_eff;
    g0_d[0] = g0_d[0] | (p0_d[0] & c0_d);
    v0_d    = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g0_q <= '0;
      p0_q <= '0;
      c0_q <= 1'b0;
      v0_q <= 1'b0;
    end else if (en) begin
      g0_q <= g0_d;
      p0_q <= p0_d;
      c0_q <= c0_d;
      v0_q <= v0_d;
    end
  end

  // The unmodified operand propagate doubles as the sum-propagate vector.
  assign g_s[0]  = g0_q;
  assign p_s[0]  = p0_q;
  assign xp_s[0] = p0_q;
  assign c_s[0]  = c0_q;
  assign v_s[0]  = v0_q;

  for (genvar k = 0; k < LOG2W; k++) begin : g_level
    prefix_level #(
      .WIDTH (WIDTH),
      .LEVEL (k),
      .REG   (PIPE_MASK[k])
    ) u_level (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .g_i  (g_s[k]),
      .p_i  (p_s[k]),
      .xp_i (xp_s[k]),
      .c_i  (c_s[k]),
      .v_i  (v_s[k]),
      .g_o  (g_s[k+1]),
      .p_o  (p_s[k+1]),
      .xp_o (xp_s[k+1]),
      .c_o  (c_s[k+1]),
      .v_o  (v_s[k+1])
    );
  end

  assign unused_p = ^p_s[LOG2W];

  always_comb begin
    sum_d        = xp_s[LOG2W] ^ {g_s[LOG2W][WIDTH-2:0], c_s[LOG2W]};
    flags_d.cout = g_s[LOG2W][WIDTH-1];
    flags_d.ovf  = g_s[LOG2W][WIDTH-1] ^ g_s[LOG2W][WIDTH-2];
    flags_d.zero = ~|sum_d;
    out_valid_d  = v_s[LOG2W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = flags_q.cout;
  assign bus.ovf       = flags_q.ovf;
  assign bus.zero      = flags_q.zero;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: a 64-bit default-mask instance and an 8-bit fully
// registered instance, each with an expected-result queue checked at the output.
module tb_prefix_adder_pipe;
  import prefix_adder_pipe_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_pop64;

  logic [66:0] exp64_q[$];
  logic [10:0] exp8_q[$];

  prefix_adder_pipe_if #(.WIDTH(64)) bus64 ();
  prefix_adder_pipe_if #(.WIDTH(8))  bus8 ();

  prefix_adder_pipe #(.WIDTH(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  prefix_adder_pipe #(.WIDTH(8), .PIPE_MASK(8'b0000_0111)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] bb;
    logic [64:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
    ovf  = (a[63] == bb[63]) && (full[63] != a[63]);
    return {full[63:0] == 64'd0, ovf, full[64], full[63:0]};
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
    ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return {full[7:0] == 8'd0, ovf, full[8], full[7:0]};
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (!rst && bus64.out_valid) begin
      if (exp64_q.size() == 0)
        check_eq("spurious64", 128'(bus64.out_valid), 128'(0));
      else if (bus64.out_ready) begin
        check_eq("res64", 128'({bus64.zero, bus64.ovf, bus64.cout, bus64.sum}), 128'(exp64_q.pop_front()));
        n_pop64++;
      end else
        check_eq("hold64", 128'({bus64.zero, bus64.ovf, bus64.cout, bus64.sum}), 128'(exp64_q[0]));
    end
  end

  always @(negedge clk) begin
    if (!rst && bus8.out_valid) begin
      if (exp8_q.size() == 0)
        check_eq("spurious8", 128'(bus8.out_valid), 128'(0));
      else if (bus8.out_ready)
        check_eq("res8", 128'({bus8.zero, bus8.ovf, bus8.cout, bus8.sum}), 128'(exp8_q.pop_front()));
      else
        check_eq("hold8", 128'({bus8.zero, bus8.ovf, bus8.cout, bus8.sum}), 128'(exp8_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic single64(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic [63:0] es,
                          input logic ec, input logic eo, input int el);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    @(posedge clk); #1;
    bus64.a = a; bus64.b = b; bus64.cin = cin; bus64.sub = sub;
    bus64.in_valid = 1'b1; bus64.out_ready = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus64.in_valid && bus64.in_ready) exp64_q.push_back(model64(a, b, cin, sub));
      if (bus64.out_valid) begin
        seen = 1;
        check_eq({tag, "_sum"},  128'(bus64.sum),  128'(es));
        check_eq({tag, "_cout"}, 128'(bus64.cout), 128'(ec));
        check_eq({tag, "_ovf"},  128'(bus64.ovf),  128'(eo));
        check_eq({tag, "_zero"}, 128'(bus64.zero), 128'(es == 64'd0));
      end else lat++;
      @(posedge clk); #1;
      bus64.in_valid = 1'b0;
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'(el));
  endtask

  task automatic single8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic [7:0] es,
                         input logic ec, input int el);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    @(posedge clk); #1;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus8.in_valid && bus8.in_ready) exp8_q.push_back(model8(a, b, cin, sub));
      if (bus8.out_valid) begin
        seen = 1;
        check_eq({tag, "_sum"},  128'(bus8.sum),  128'(es));
        check_eq({tag, "_cout"}, 128'(bus8.cout), 128'(ec));
      end else lat++;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'(el));
  endtask

  task automatic drain64();
    @(posedge clk); #1;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
    for (int n = 0; n < 30 && exp64_q.size() != 0; n++) @(posedge clk);
    check_eq("drain64_left", 128'(exp64_q.size()), 128'(0));
  endtask

  task automatic stream64();
    int idx;
    int pops0;
    idx   = 0;
    pops0 = n_pop64;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      @(posedge clk); #1;
      bus64.out_ready = !(cyc >= 4 && cyc <= 6);
      bus64.in_valid  = 1'b1;
      bus64.a   = 64'(idx);
      bus64.b   = 64'(idx) << 32;
      bus64.cin = 1'b0;
      bus64.sub = 1'b0;
      @(negedge clk);
      if (cyc >= 4 && cyc <= 6) begin
        check_eq("stall_in_ready",  128'(bus64.in_ready),  128'(0));
        check_eq("stall_out_valid", 128'(bus64.out_valid), 128'(1));
      end
      if (cyc == 7) check_eq("resume_in_ready", 128'(bus64.in_ready), 128'(1));
      if (bus64.in_ready) begin
        exp64_q.push_back(model64(bus64.a, bus64.b, 1'b0, 1'b0));
        idx++;
      end
    end
    drain64();
    check_eq("stream_count", 128'(n_pop64 - pops0), 128'(8));
  endtask

  task automatic reset_midstream64();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      bus64.out_ready = 1'b1;
      bus64.in_valid  = 1'b1;
      bus64.a = {$urandom, $urandom};
      bus64.b = {$urandom, $urandom};
      @(negedge clk);
      if (bus64.in_ready) exp64_q.push_back(model64(bus64.a, bus64.b, bus64.cin, bus64.sub));
    end
    @(posedge clk); #1;
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b0;
    rst = 1'b1;
    exp64_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_out_valid", 128'(bus64.out_valid), 128'(0));
    check_eq("rst_mid_in_ready",  128'(bus64.in_ready),  128'(1));
    bus64.out_ready = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic random8();
    int  sent;
    bit  acc;
    sent = 0;
    acc  = 0;
    for (int cyc = 0; cyc < 20000 && sent < 2000; cyc++) begin
      @(posedge clk); #1;
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !bus8.in_valid) begin
        bus8.in_valid = ($urandom_range(0, 4) != 0);
        bus8.a   = 8'($urandom_range(0, 255));
        bus8.b   = 8'($urandom_range(0, 255));
        bus8.cin = 1'($urandom_range(0, 1));
        bus8.sub = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      acc = bus8.in_valid && bus8.in_ready;
      if (acc) begin
        exp8_q.push_back(model8(bus8.a, bus8.b, bus8.cin, bus8.sub));
        sent++;
      end
    end
    check_eq("rand8_sent", 128'(sent), 128'(2000));
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    for (int n = 0; n < 50 && exp8_q.size() != 0; n++) @(posedge clk);
    check_eq("drain8_left", 128'(exp8_q.size()), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_pop64  = 0;
    rst = 1'b1;
    bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.cin = 1'b0; bus64.sub = 1'b0;
    bus64.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst64_out_valid", 128'(bus64.out_valid), 128'(0));
    check_eq("rst64_sum",       128'(bus64.sum),       128'(0));
    check_eq("rst64_flags",     128'({bus64.cout, bus64.ovf, bus64.zero}), 128'(0));
    check_eq("rst64_in_ready",  128'(bus64.in_ready),  128'(1));
    check_eq("rst8_out_valid",  128'(bus8.out_valid),  128'(0));
    check_eq("rst8_sum",        128'(bus8.sum),        128'(0));
    check_eq("rst8_flags",      128'({bus8.cout, bus8.ovf, bus8.zero}), 128'(0));
    check_eq("rst8_in_ready",   128'(bus8.in_ready),   128'(1));

    single64("wrap",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 3);
    single64("sovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3);
    single64("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 3);
    single64("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 3);
    single64("sub_cin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0, 3);
    single64("add_cin", 64'd1, 64'd2, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0, 3);
    single8("w8", 8'hF0, 8'h10, 1'b1, 1'b0, 8'h01, 1'b1, 5);

    stream64();
    reset_midstream64();
    random8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
